// File: rtl/freq_gen_pkg.sv
// rtl/freq_gen_pkg.sv - shared state type and defaults for the square-wave generator
package freq_gen_pkg;

    // Width of period / high-time fields (262,143 clocks max at 18 bits).
    localparam int COUNTER_WIDTH_DEF = 18;
    // Smallest legal period in clocks.
    localparam int MIN_PERIOD_DEF    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } fg_state_e;

endpackage

// File: rtl/freq_gen_cfg_buf.sv
// rtl/freq_gen_cfg_buf.sv - config handshake, legality check and one-deep pending slot
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_valid / cfg_ready      config handshake; ready is low exactly while the slot is full
//   cfg_period / cfg_high      offered period P and high time H
//   cfg_err                    one-cycle pulse the cycle after an illegal config is accepted
//   bypass                     accepted legal config goes straight to the active set, not the slot
//   take                       period boundary: the slot drains into the active set
//   acc_legal                  a legal config is accepted on this edge
//   pend_valid/period/high     pending slot contents
module freq_gen_cfg_buf
    import freq_gen_pkg::*;
#(
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
    parameter int MIN_PERIOD    = MIN_PERIOD_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [COUNTER_WIDTH-1:0] cfg_period,
    input  logic [COUNTER_WIDTH-1:0] cfg_high,
    output logic                     cfg_err,
    input  logic                     bypass,
    input  logic                     take,
    output logic                     acc_legal,
    output logic                     pend_valid,
    output logic [COUNTER_WIDTH-1:0] pend_period,
    output logic [COUNTER_WIDTH-1:0] pend_high
);

    logic                     legal;
    logic                     pend_valid_q, pend_valid_d;
    logic [COUNTER_WIDTH-1:0] pend_period_q, pend_period_d;
    logic [COUNTER_WIDTH-1:0] pend_high_q, pend_high_d;
    logic                     cfg_err_q, cfg_err_d;

    assign legal     = (cfg_period >= COUNTER_WIDTH'(MIN_PERIOD)) &&
                       (cfg_high != '0) && (cfg_high < cfg_period);
    assign cfg_ready = ~pend_valid_q;
    assign acc_legal = cfg_valid && cfg_ready && legal;

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_period_d = pend_period_q;
        pend_high_d   = pend_high_q;
        cfg_err_d     = cfg_valid && cfg_ready && !legal;
        if (take) begin
            pend_valid_d = 1'b0;
        end
        // A config accepted on a boundary lands after the drain, so it waits a full period.
        if (acc_legal && !bypass) begin
            pend_valid_d  = 1'b1;
            pend_period_d = cfg_period;
            pend_high_d   = cfg_high;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q  <= 1'b0;
            pend_period_q <= '0;
            pend_high_q   <= '0;
            cfg_err_q     <= 1'b0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_period_q <= pend_period_d;
            pend_high_q   <= pend_high_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign cfg_err     = cfg_err_q;
    assign pend_valid  = pend_valid_q;
    assign pend_period = pend_period_q;
    assign pend_high   = pend_high_q;

endmodule

// File: rtl/freq_gen_square.sv
// rtl/freq_gen_square.sv - programmable square-wave generator with glitch-free config updates
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   en                         run request
//   cfg_valid / cfg_ready      config handshake (ready low while a config is pending)
//   cfg_period / cfg_high      period P and high time H in clocks
//   cfg_err                    one-cycle pulse after an illegal config is dropped
//   sq_out                     registered square wave: H clocks high, P-H clocks low
//   cycle_start                high during the first high clock of each period
//   running                    high while a waveform is being produced (RUN or draining in STOP)
//   period_active              P of the period currently being generated
module freq_gen_square
    import freq_gen_pkg::*;
#(
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
    parameter int MIN_PERIOD    = MIN_PERIOD_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [COUNTER_WIDTH-1:0] cfg_period,
    input  logic [COUNTER_WIDTH-1:0] cfg_high,
    output logic                     cfg_err,
    output logic                     sq_out,
    output logic                     cycle_start,
    output logic                     running,
    output logic [COUNTER_WIDTH-1:0] period_active
);

    fg_state_e                state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] act_period_q, act_period_d;
    logic [COUNTER_WIDTH-1:0] act_high_q, act_high_d;
    logic                     act_valid_q, act_valid_d;
    logic                     sq_out_q, sq_out_d;
    logic                     cycle_start_q, cycle_start_d;
    logic                     running_q, running_d;
    logic [COUNTER_WIDTH-1:0] period_active_q, period_active_d;

    logic                     start;
    logic                     boundary;
    logic                     bypass;
    logic                     take;
    logic                     acc_legal;
    logic                     pend_valid;
    logic [COUNTER_WIDTH-1:0] pend_period;
    logic [COUNTER_WIDTH-1:0] pend_high;
    logic [COUNTER_WIDTH-1:0] next_period;
    logic [COUNTER_WIDTH-1:0] cnt_inc;

    assign start       = (state_q == IDLE) && en && act_valid_q;
    assign boundary    = (cnt_q == act_period_q - 1'b1);
    assign take        = (state_q != IDLE) && boundary;
    // On the start edge the active set is already in use, so a new config must queue.
    assign bypass      = (state_q == IDLE) && !start;
    assign next_period = pend_valid ? pend_period : act_period_q;
    assign cnt_inc     = cnt_q + 1'b1;

    freq_gen_cfg_buf #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .MIN_PERIOD    (MIN_PERIOD)
    ) u_cfg_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_err     (cfg_err),
        .bypass      (bypass),
        .take        (take),
        .acc_legal   (acc_legal),
        .pend_valid  (pend_valid),
        .pend_period (pend_period),
        .pend_high   (pend_high)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        act_period_d    = act_period_q;
        act_high_d      = act_high_q;
        act_valid_d     = act_valid_q;
        sq_out_d        = sq_out_q;
        cycle_start_d   = cycle_start_q;
        running_d       = running_q;
        period_active_d = period_active_q;

        case (state_q)
            IDLE: begin
                sq_out_d      = 1'b0;
                cycle_start_d = 1'b0;
                running_d     = 1'b0;
                if (start) begin
                    state_d         = RUN;
                    cnt_d           = '0;
                    sq_out_d        = 1'b1;
                    cycle_start_d   = 1'b1;
                    running_d       = 1'b1;
                    period_active_d = act_period_q;
                end else if (acc_legal) begin
                    act_period_d = cfg_period;
                    act_high_d   = cfg_high;
                    act_valid_d  = 1'b1;
                end
            end
            RUN, STOP: begin
                if (boundary) begin
                    if (pend_valid) begin
                        act_period_d = pend_period;
                        act_high_d   = pend_high;
                    end
                    cnt_d = '0;
                    if (en) begin
                        // H >= 1 is guaranteed, so every period opens high.
                        state_d         = RUN;
                        sq_out_d        = 1'b1;
                        cycle_start_d   = 1'b1;
                        running_d       = 1'b1;
                        period_active_d = next_period;
                    end else begin
                        state_d         = IDLE;
                        sq_out_d        = 1'b0;
                        cycle_start_d   = 1'b0;
                        running_d       = 1'b0;
                        period_active_d = '0;
                    end
                end else begin
                    cnt_d         = cnt_inc;
                    sq_out_d      = (cnt_inc < act_high_q);
                    cycle_start_d = 1'b0;
                    running_d     = 1'b1;
                    state_d       = en ? RUN : STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            act_period_q    <= '0;
            act_high_q      <= '0;
            act_valid_q     <= 1'b0;
            sq_out_q        <= 1'b0;
            cycle_start_q   <= 1'b0;
            running_q       <= 1'b0;
            period_active_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            act_period_q    <= act_period_d;
            act_high_q      <= act_high_d;
            act_valid_q     <= act_valid_d;
            sq_out_q        <= sq_out_d;
            cycle_start_q   <= cycle_start_d;
            running_q       <= running_d;
            period_active_q <= period_active_d;
        end
    end

    assign sq_out        = sq_out_q;
    assign cycle_start   = cycle_start_q;
    assign running       = running_q;
    assign period_active = period_active_q;

endmodule

// File: tb/tb_freq_gen_square.sv
// tb/tb_freq_gen_square.sv - self-checking bench for freq_gen_square
module tb_freq_gen_square;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic         cfg_ready;
    logic         cfg_err;
    logic         sq_out;
    logic         cycle_start;
    logic         running;
    logic [W-1:0] period_active;

    always #5 clk = ~clk;

    freq_gen_square dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_high      (cfg_high),
        .cfg_err       (cfg_err),
        .sq_out        (sq_out),
        .cycle_start   (cycle_start),
        .running       (running),
        .period_active (period_active)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the waveform of the current period is a queue of samples.
    int m_mode;          // 0 idle, 1 run, 2 stop
    bit m_act;
    int m_p, m_h;
    bit m_pend;
    int m_pp, m_ph;
    bit wave[$];         // samples still to come after the current one
    bit e_sq, e_cs, e_run, e_err, e_rdy;
    int e_pa;

    int cs_seen;
    int ones;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_act = 0; m_pend = 0; m_p = 0; m_h = 0;
        wave.delete();
        e_sq = 0; e_cs = 0; e_run = 0; e_err = 0; e_rdy = 1; e_pa = 0;
    endtask

    task automatic new_period();
        wave.delete();
        for (int i = 0; i < m_p; i++) wave.push_back(i < m_h);
        e_sq = wave.pop_front();
        e_cs = 1;
        e_pa = m_p;
    endtask

    task automatic model_edge();
        bit acc, legal;
        acc   = cfg_valid && !m_pend;
        legal = (cfg_period >= 2) && (cfg_high >= 1) && (cfg_high < cfg_period);
        e_err = acc && !legal;
        if (m_mode == 0) begin
            e_sq = 0; e_cs = 0;
            if (en && m_act) begin
                m_mode = 1;
                new_period();
                if (acc && legal) begin m_pend = 1; m_pp = cfg_period; m_ph = cfg_high; end
            end else if (acc && legal) begin
                m_act = 1; m_p = cfg_period; m_h = cfg_high;
            end
        end else if (wave.size() == 0) begin
            if (m_pend) begin m_p = m_pp; m_h = m_ph; m_pend = 0; end
            if (acc && legal) begin m_pend = 1; m_pp = cfg_period; m_ph = cfg_high; end
            if (en) begin
                m_mode = 1;
                new_period();
            end else begin
                m_mode = 0; e_sq = 0; e_cs = 0; e_pa = 0;
            end
        end else begin
            e_sq = wave.pop_front();
            e_cs = 0;
            m_mode = en ? 1 : 2;
            if (acc && legal) begin m_pend = 1; m_pp = cfg_period; m_ph = cfg_high; end
        end
        e_run = (m_mode != 0);
        e_rdy = !m_pend;
    endtask

    task automatic check_all();
        chk("sq_out", sq_out, e_sq);
        chk("cycle_start", cycle_start, e_cs);
        chk("running", running, e_run);
        chk("cfg_err", cfg_err, e_err);
        chk("cfg_ready", cfg_ready, e_rdy);
        chk("period_active", period_active, e_pa);
    endtask

    task automatic tick(input logic t_en, input logic t_v, input int t_p, input int t_h);
        en = t_en; cfg_valid = t_v;
        cfg_period = W'(t_p); cfg_high = W'(t_h);
        model_edge();
        @(negedge clk);
        check_all();
        ones += int'(sq_out);
        if (cycle_start) cs_seen++;
    endtask

    initial begin
        int n;
        rst_n = 0; en = 0; cfg_valid = 0; cfg_period = '0; cfg_high = '0;
        repeat (2) @(negedge clk);
        model_reset();
        check_all();
        rst_n = 1;

        // 1000/500 for ten periods
        tick(0, 1, 1000, 500);
        cs_seen = 0; ones = 0;
        for (int i = 0; i < 10000; i++) tick(1, 0, 0, 0);
        chk("cs_count_10p", cs_seen, 10);
        chk("high_count_10p", ones, 5000);

        // mid-period update to 400/100
        for (int i = 0; i < 300; i++) tick(1, 0, 0, 0);
        tick(1, 1, 400, 100);
        chk("ready_low_pending", cfg_ready, 0);
        n = 0;
        do begin tick(1, 0, 0, 0); n++; end while (!cycle_start && n < 2000);
        chk("old_period_len", n, 700);
        chk("new_pa", period_active, 400);
        chk("ready_back", cfg_ready, 1);
        ones = 1;
        for (int i = 0; i < 399; i++) tick(1, 0, 0, 0);
        chk("p400_high", ones, 100);
        tick(1, 0, 0, 0);
        chk("p400_wrap", cycle_start, 1);

        // illegal configs
        tick(1, 1, 1, 0);
        chk("err_p1h0", cfg_err, 1);
        tick(1, 0, 0, 0);
        chk("err_clear1", cfg_err, 0);
        tick(1, 1, 10, 10);
        chk("err_p10h10", cfg_err, 1);
        tick(1, 0, 0, 0);
        chk("err_clear2", cfg_err, 0);
        chk("pa_unchanged", period_active, 400);

        // switch to 20/10, then drop en mid-high
        tick(1, 1, 20, 10);
        n = 0;
        do begin tick(1, 0, 0, 0); n++; end while (!cycle_start && n < 1000);
        chk("pa_20", period_active, 20);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0);
        n = 0;
        do begin tick(0, 0, 0, 0); n++; end while (running && n < 60);
        chk("stop_len", n, 17);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0);
            chk("idle_sq", sq_out, 0);
        end
        tick(1, 0, 0, 0);
        chk("restart_cs", cycle_start, 1);
        n = 0;
        for (int i = 0; i < 4; i++) begin tick(1, 0, 0, 0); n++; end
        for (int i = 0; i < 5; i++) begin tick(0, 0, 0, 0); n++; end
        do begin tick(1, 0, 0, 0); n++; end while (!cycle_start && n < 60);
        chk("reraise_no_gap", n, 20);

        // config on the exact boundary clock
        n = 0;
        while (wave.size() != 0 && n < 60) begin tick(1, 0, 0, 0); n++; end
        tick(1, 1, 30, 7);
        chk("boundary_cfg_deferred", period_active, 20);
        chk("boundary_cfg_pending", cfg_ready, 0);
        for (int i = 0; i < 20; i++) tick(1, 0, 0, 0);
        chk("boundary_cfg_applied", period_active, 30);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int p, h;
            p = $urandom_range(0, 24);
            h = $urandom_range(0, p + 1);
            tick($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, p, h);
        end

        // reset during a high phase
        n = 0;
        do begin tick(1, 1, 10, 5); n++; end while (!(sq_out && !cycle_start) && n < 100);
        chk("reached_high", sq_out, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_sq", sq_out, 0);
        chk("async_rst_run", running, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 30; i++) tick(1, 0, 0, 0);
        chk("no_cfg_no_run", running, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
